// File: rtl/wb_stage_if.sv
// Writeback-stage bus: cache-stage completion inputs, RF write/bypass, retire,
// exception/redirect outputs and the architectural RM0-RM2 registers.
interface wb_stage_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned PC_W    = 32
);
  logic               in_valid;
  logic               in_write_rf;
  logic [RADDR_W-1:0] in_dest_rf;
  logic [DATA_W-1:0]  in_data;
  logic [PC_W-1:0]    in_pc;
  logic [3:0]         in_xcpt;
  logic [PC_W-1:0]    in_xcpt_addr;
  logic               iret;
  logic               redirect_ack;

  logic               rf_we;
  logic [RADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]  rf_wdata;
  logic               bp_valid;
  logic [DATA_W-1:0]  bp_data;
  logic               retire_valid;
  logic [PC_W-1:0]    retire_pc;
  logic [31:0]        retire_count;
  logic               xcpt_flush;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic [PC_W-1:0]    rm0;
  logic [PC_W-1:0]    rm1;
  logic [PC_W-1:0]    rm2;

  modport master (
    output in_valid, in_write_rf, in_dest_rf, in_data, in_pc, in_xcpt, in_xcpt_addr, iret,
           redirect_ack,
    input  rf_we, rf_waddr, rf_wdata, bp_valid, bp_data, retire_valid, retire_pc, retire_count,
           xcpt_flush, redirect_valid, redirect_pc, rm0, rm1, rm2
  );

  modport slave (
    input  in_valid, in_write_rf, in_dest_rf, in_data, in_pc, in_xcpt, in_xcpt_addr, iret,
           redirect_ack,
    output rf_we, rf_waddr, rf_wdata, bp_valid, bp_data, retire_valid, retire_pc, retire_count,
           xcpt_flush, redirect_valid, redirect_pc, rm0, rm1, rm2
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback/commit stage: registers the RF write, retires and counts instructions,
// resolves exceptions into RM0-RM2 and sequences flush + redirect (exception or IRET).
module wb_stage #(
  parameter int unsigned     DATA_W          = 32,
  parameter int unsigned     RADDR_W         = 5,
  parameter int unsigned     PC_W            = 32,
  parameter logic [PC_W-1:0] XCPT_VECTOR     = 32'h2000,
  parameter int unsigned     FLUSH_CYCLES    = 3,
  parameter logic [31:0]     RETIRE_CNT_INIT = 32'h0
) (
  input logic       clock,
  input logic       reset,
  wb_stage_if.slave bus
);

  typedef enum logic [1:0] {StRun, StFlush, StRedirect} state_e;

  state_e             r_state, w_state_next;
  logic [3:0]         r_flush_cnt, w_flush_cnt;
  logic               r_is_iret, w_is_iret;
  logic               r_rf_we, w_rf_we;
  logic [RADDR_W-1:0] r_rf_waddr, w_rf_waddr;
  logic [DATA_W-1:0]  r_rf_wdata, w_rf_wdata;
  logic               r_retire_valid, w_retire_valid;
  logic [PC_W-1:0]    r_retire_pc, w_retire_pc;
  logic [31:0]        r_retire_count, w_retire_count;
  logic               r_xcpt_flush, w_xcpt_flush;
  logic               r_redirect_valid, w_redirect_valid;
  logic [PC_W-1:0]    r_redirect_pc, w_redirect_pc;
  logic [PC_W-1:0]    r_rm0, w_rm0;
  logic [PC_W-1:0]    r_rm1, w_rm1;
  logic [PC_W-1:0]    r_rm2, w_rm2;

  logic       w_xcpt;
  logic       w_retire;
  logic       w_iret;
  logic [2:0] w_cause;

  assign w_xcpt   = (r_state == StRun) && bus.in_valid && (bus.in_xcpt != 4'b0000);
  assign w_retire = (r_state == StRun) && bus.in_valid && (bus.in_xcpt == 4'b0000);
  assign w_iret   = w_retire && bus.iret;

  // Stage priority: the oldest stage (fetch) owns the exception.
  always_comb begin
    w_cause = 3'd4;
    if (bus.in_xcpt[3])      w_cause = 3'd1;
    else if (bus.in_xcpt[2]) w_cause = 3'd2;
    else if (bus.in_xcpt[1]) w_cause = 3'd3;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= StRun;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StRun:      if (w_xcpt || w_iret) w_state_next = StFlush;
      StFlush:    if (r_flush_cnt == 4'd0) w_state_next = StRedirect;
      StRedirect: if (bus.redirect_ack) w_state_next = StRun;
      default:    w_state_next = StRun;
    endcase
  end

  always_comb begin
    w_flush_cnt    = r_flush_cnt;
    w_is_iret      = r_is_iret;
    w_rf_we        = 1'b0;
    w_rf_waddr     = r_rf_waddr;
    w_rf_wdata     = r_rf_wdata;
    w_retire_valid = 1'b0;
    w_retire_pc    = r_retire_pc;
    w_retire_count = r_retire_count;
    w_rm0          = r_rm0;
    w_rm1          = r_rm1;
    w_rm2          = r_rm2;
    case (r_state)
      StRun: begin
        if (w_retire) begin
          w_rf_we        = bus.in_write_rf && !bus.iret;
          w_rf_waddr     = bus.in_dest_rf;
          w_rf_wdata     = bus.in_data;
          w_retire_valid = 1'b1;
          w_retire_pc    = bus.in_pc;
          w_retire_count = r_retire_count + 32'd1;
        end
        if (w_xcpt) begin
          w_rm0 = bus.in_pc;
          w_rm1 = (w_cause == 3'd1 || w_cause == 3'd4) ? bus.in_xcpt_addr : '0;
          w_rm2 = {{(PC_W-3){1'b0}}, w_cause};
        end
        if (w_xcpt || w_iret) begin
          w_is_iret   = w_iret;
          w_flush_cnt = 4'(FLUSH_CYCLES - 1);
        end
      end
      StFlush: if (r_flush_cnt != 4'd0) w_flush_cnt = r_flush_cnt - 4'd1;
      default: ;
    endcase
    w_xcpt_flush     = (w_state_next == StFlush);
    w_redirect_valid = (w_state_next == StRedirect);
    w_redirect_pc    = '0;
    if (w_state_next == StRedirect) w_redirect_pc = r_is_iret ? r_rm0 : XCPT_VECTOR;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_flush_cnt      <= '0;
      r_is_iret        <= 1'b0;
      r_rf_we          <= 1'b0;
      r_rf_waddr       <= '0;
      r_rf_wdata       <= '0;
      r_retire_valid   <= 1'b0;
      r_retire_pc      <= '0;
      r_retire_count   <= RETIRE_CNT_INIT;
      r_xcpt_flush     <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_rm0            <= '0;
      r_rm1            <= '0;
      r_rm2            <= '0;
    end else begin
      r_flush_cnt      <= w_flush_cnt;
      r_is_iret        <= w_is_iret;
      r_rf_we          <= w_rf_we;
      r_rf_waddr       <= w_rf_waddr;
      r_rf_wdata       <= w_rf_wdata;
      r_retire_valid   <= w_retire_valid;
      r_retire_pc      <= w_retire_pc;
      r_retire_count   <= w_retire_count;
      r_xcpt_flush     <= w_xcpt_flush;
      r_redirect_valid <= w_redirect_valid;
      r_redirect_pc    <= w_redirect_pc;
      r_rm0            <= w_rm0;
      r_rm1            <= w_rm1;
      r_rm2            <= w_rm2;
    end
  end

  assign bus.rf_we          = r_rf_we;
  assign bus.rf_waddr       = r_rf_waddr;
  assign bus.rf_wdata       = r_rf_wdata;
  assign bus.bp_valid       = r_rf_we;
  assign bus.bp_data        = r_rf_wdata;
  assign bus.retire_valid   = r_retire_valid;
  assign bus.retire_pc      = r_retire_pc;
  assign bus.retire_count   = r_retire_count;
  assign bus.xcpt_flush     = r_xcpt_flush;
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.rm0            = r_rm0;
  assign bus.rm1            = r_rm1;
  assign bus.rm2            = r_rm2;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: event-level reference model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_wb_stage;
  localparam int FLUSH = 3;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  wb_stage_if bus ();
  wb_stage_if bus2 ();

  wb_stage dut (.clock(clock), .reset(reset), .bus(bus));
  wb_stage #(.RETIRE_CNT_INIT(32'hFFFF_FFFF)) dut2 (.clock(clock), .reset(reset), .bus(bus2));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected outputs after each clock edge.
  logic        e_rf_we = 0, e_ret = 0, e_flush = 0, e_redir = 0;
  logic [4:0]  e_waddr = '0;
  logic [31:0] e_wdata = '0, e_retpc = '0, e_count = '0, e_rpc = '0, e_target = '0;
  logic [31:0] e_rm0 = '0, e_rm1 = '0, e_rm2 = '0;
  int          e_flush_done = 0;
  logic [2:0]  m_cause;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      e_rf_we = 0; e_ret = 0; e_flush = 0; e_redir = 0; e_waddr = '0; e_wdata = '0;
      e_retpc = '0; e_count = '0; e_rpc = '0; e_target = '0; e_rm0 = '0; e_rm1 = '0;
      e_rm2 = '0; e_flush_done = 0;
    end else begin
      e_rf_we = 0;
      e_ret   = 0;
      if (e_flush) begin
        e_flush_done++;
        if (e_flush_done == FLUSH) begin
          e_flush = 0; e_redir = 1; e_rpc = e_target;
        end
      end else if (e_redir) begin
        if (bus.redirect_ack) begin e_redir = 0; e_rpc = '0; end
      end else if (bus.in_valid) begin
        if (bus.in_xcpt != 4'b0) begin
          m_cause = bus.in_xcpt[3] ? 3'd1 : bus.in_xcpt[2] ? 3'd2 : bus.in_xcpt[1] ? 3'd3 : 3'd4;
          e_rm0 = bus.in_pc;
          e_rm1 = (m_cause == 3'd1 || m_cause == 3'd4) ? bus.in_xcpt_addr : 32'h0;
          e_rm2 = {29'b0, m_cause};
          e_target = 32'h2000;
          e_flush = 1; e_flush_done = 0;
        end else begin
          e_rf_we = bus.in_write_rf && !bus.iret;
          e_waddr = bus.in_dest_rf;
          e_wdata = bus.in_data;
          e_ret   = 1;
          e_retpc = bus.in_pc;
          e_count = e_count + 32'd1;
          if (bus.iret) begin e_target = e_rm0; e_flush = 1; e_flush_done = 0; end
        end
      end
    end
  end

  always @(negedge clock) begin
    chk("rf_we", bus.rf_we, e_rf_we);
    chk("rf_waddr", bus.rf_waddr, e_waddr);
    chk("rf_wdata", bus.rf_wdata, e_wdata);
    chk("bp_valid", bus.bp_valid, e_rf_we);
    chk("bp_data", bus.bp_data, e_wdata);
    chk("retire_valid", bus.retire_valid, e_ret);
    chk("retire_pc", bus.retire_pc, e_retpc);
    chk("retire_count", bus.retire_count, e_count);
    chk("xcpt_flush", bus.xcpt_flush, e_flush);
    chk("redirect_valid", bus.redirect_valid, e_redir);
    chk("redirect_pc", bus.redirect_pc, e_rpc);
    chk("rm0", bus.rm0, e_rm0);
    chk("rm1", bus.rm1, e_rm1);
    chk("rm2", bus.rm2, e_rm2);
  end

  task automatic drv(input logic v, input logic w, input logic [4:0] d, input logic [31:0] data,
                     input logic [31:0] pc, input logic [3:0] x, input logic [31:0] xa,
                     input logic ir);
    bus.in_valid = v; bus.in_write_rf = w; bus.in_dest_rf = d; bus.in_data = data;
    bus.in_pc = pc; bus.in_xcpt = x; bus.in_xcpt_addr = xa; bus.iret = ir;
    bus.redirect_ack = 1'b0;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 4'b0, 32'h0, 1'b0);
  endtask

  // Counts flush cycles until redirect_valid is seen, bounded.
  task automatic wait_redirect(output int nflush);
    nflush = 0;
    for (int i = 0; i < 20 && !bus.redirect_valid; i++) begin
      if (bus.xcpt_flush) nflush++;
      @(negedge clock);
    end
    chk("redirect_reached", bus.redirect_valid, 1'b1);
  endtask

  initial begin
    int nf;
    reset = 1'b0;
    idle();
    bus2.in_valid = 0; bus2.in_write_rf = 0; bus2.in_dest_rf = '0; bus2.in_data = '0;
    bus2.in_pc = '0; bus2.in_xcpt = '0; bus2.in_xcpt_addr = '0; bus2.iret = 0;
    bus2.redirect_ack = 0;
    repeat (2) @(negedge clock);
    chk("rst_count", bus.retire_count, 32'h0);
    chk("rst_rf_we", bus.rf_we, 1'b0);
    chk("rst_redirect", bus.redirect_valid, 1'b0);
    reset = 1'b1;

    // ALU write
    @(negedge clock);
    drv(1, 1, 5'd5, 32'hDEAD, 32'h1000, 4'b0, 32'h0, 0);
    @(negedge clock);
    idle();
    chk("t1_we", bus.rf_we, 1'b1);
    chk("t1_waddr", bus.rf_waddr, 5'd5);
    chk("t1_wdata", bus.rf_wdata, 32'hDEAD);
    chk("t1_bp", bus.bp_valid, 1'b1);
    chk("t1_rpc", bus.retire_pc, 32'h1000);
    chk("t1_cnt", bus.retire_count, 32'd1);
    @(negedge clock);
    chk("t1_hold_we", bus.rf_we, 1'b0);
    chk("t1_hold_waddr", bus.rf_waddr, 5'd5);

    // Cache fault, junk inputs during flush/redirect, ack on first redirect cycle
    drv(1, 1, 5'd9, 32'h1234, 32'h1080, 4'b0001, 32'hBEEF, 0);
    @(negedge clock);
    drv(1, 1, 5'd7, 32'h55, 32'h1084, 4'b0, 32'h0, 0);
    chk("t3_rm2", bus.rm2, 32'd4);
    chk("t3_rm1", bus.rm1, 32'hBEEF);
    chk("t3_we", bus.rf_we, 1'b0);
    wait_redirect(nf);
    chk("t3_nflush", nf, FLUSH);
    chk("t3_rpc", bus.redirect_pc, 32'h2000);
    chk("t3_cnt", bus.retire_count, 32'd1);
    idle();
    bus.redirect_ack = 1'b1;
    @(negedge clock);
    bus.redirect_ack = 1'b0;
    chk("t3_redir_done", bus.redirect_valid, 1'b0);

    // Priority fetch > alu-less mix (decode + cache): decode wins
    drv(1, 1, 5'd3, 32'h1, 32'h1040, 4'b0101, 32'h8, 0);
    @(negedge clock);
    drv(1, 1, 5'd7, 32'h66, 32'h1044, 4'b0, 32'h0, 0);
    chk("t2_rm2", bus.rm2, 32'd2);
    chk("t2_rm0", bus.rm0, 32'h1040);
    chk("t2_rm1", bus.rm1, 32'h0);
    chk("t2_we", bus.rf_we, 1'b0);
    wait_redirect(nf);
    chk("t2_nflush", nf, FLUSH);
    idle();
    repeat (3) begin
      @(negedge clock);
      chk("t2_hold_rpc", bus.redirect_pc, 32'h2000);
    end
    bus.redirect_ack = 1'b1;
    @(negedge clock);
    bus.redirect_ack = 1'b0;
    chk("t2_redir_done", bus.redirect_valid, 1'b0);

    // IRET back to rm0 with late ack
    drv(1, 1, 5'd4, 32'h77, 32'h1100, 4'b0, 32'h0, 1);
    @(negedge clock);
    idle();
    chk("t4_cnt", bus.retire_count, 32'd2);
    chk("t4_we", bus.rf_we, 1'b0);
    chk("t4_ret", bus.retire_valid, 1'b1);
    wait_redirect(nf);
    chk("t4_nflush", nf, FLUSH);
    chk("t4_rpc", bus.redirect_pc, 32'h1040);
    repeat (5) begin
      @(negedge clock);
      chk("t4_hold_rpc", bus.redirect_pc, 32'h1040);
    end
    bus.redirect_ack = 1'b1;
    @(negedge clock);
    bus.redirect_ack = 1'b0;
    chk("t4_redir_done", bus.redirect_valid, 1'b0);
    drv(1, 1, 5'd6, 32'hCAFE, 32'h1040, 4'b0, 32'h0, 0);
    @(negedge clock);
    idle();
    chk("t4_run_we", bus.rf_we, 1'b1);
    chk("t4_run_cnt", bus.retire_count, 32'd3);

    // Exception and iret together: exception (alu) wins
    drv(1, 1, 5'd2, 32'h9, 32'h2004, 4'b0010, 32'h99, 1);
    @(negedge clock);
    idle();
    chk("t4b_rm2", bus.rm2, 32'd3);
    chk("t4b_rm1", bus.rm1, 32'h0);
    chk("t4b_cnt", bus.retire_count, 32'd3);
    wait_redirect(nf);
    chk("t4b_rpc", bus.redirect_pc, 32'h2000);
    bus.redirect_ack = 1'b1;
    @(negedge clock);
    bus.redirect_ack = 1'b0;

    // Counter wrap on the preset instance
    chk("t5_pre", bus2.retire_count, 32'hFFFF_FFFF);
    bus2.in_valid = 1; bus2.in_write_rf = 1; bus2.in_dest_rf = 5'd1; bus2.in_pc = 32'h3000;
    @(negedge clock);
    bus2.in_valid = 0;
    chk("t5_wrap", bus2.retire_count, 32'h0);
    chk("t5_ret", bus2.retire_valid, 1'b1);

    // Reset during flush
    drv(1, 0, 5'd0, 32'h0, 32'h2100, 4'b1000, 32'h44, 0);
    @(negedge clock);
    idle();
    chk("t6_flush", bus.xcpt_flush, 1'b1);
    chk("t6_rm1", bus.rm1, 32'h44);
    #2 reset = 1'b0;
    #1;
    chk("t6_flush_rst", bus.xcpt_flush, 1'b0);
    chk("t6_redir_rst", bus.redirect_valid, 1'b0);
    chk("t6_rm0_rst", bus.rm0, 32'h0);
    chk("t6_cnt_rst", bus.retire_count, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    drv(1, 1, 5'd8, 32'hF00D, 32'h2200, 4'b0, 32'h0, 0);
    @(negedge clock);
    idle();
    chk("t6_we", bus.rf_we, 1'b1);
    chk("t6_wdata", bus.rf_wdata, 32'hF00D);
    chk("t6_cnt", bus.retire_count, 32'd1);
    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
